bit_scan_unpacker: RTL and testbench

- Sequential inverse of the bitwise combine path: the ALU's bitwise OR merges flag bits into one 32-bit word; this block takes such a word apart again.
- Accepts a 32-bit mask (interrupt/exception flag word or register-dependency mask) and emits the index of each set bit, one per cycle, over a valid/ready stream.
- Sits between flag-collecting logic and per-source handlers in the processor datapath.

---
 rtl/bit_scan_unpacker.sv | 111 +++++++++++
 tb/tb_bit_scan_unpacker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_unpacker.sv
// Unpacks a flag/dependency mask into a stream of set-bit indices, one per cycle.
// Optional BITSCAN_MSB_FIRST_EN emits the highest set bit first instead of the lowest.
module bit_scan_unpacker #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDXW  = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_index,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   if (IDXW != $clog2(WIDTH)) begin : g_bad_idxw
      $error("IDXW must equal clog2(WIDTH)");
   end

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   state_t           state;
   logic [WIDTH-1:0] residual;
   logic [WIDTH-1:0] low_cleared;
   logic [WIDTH-1:0] residual_next;
   logic [IDXW-1:0]  scan_index;
   logic             scan_last;

   // Index and last flag come only from the registered residual.
   always_comb begin
      scan_index  = '0;
      low_cleared = residual & (residual - WIDTH'(1));
`ifdef BITSCAN_MSB_FIRST_EN
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (residual[i]) scan_index = IDXW'(i);
      end
      residual_next = residual & ~(WIDTH'(1) << scan_index);
`else
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (residual[i]) scan_index = IDXW'(i);
      end
      residual_next = low_cleared;
`endif
      scan_last = (residual != '0) && (low_cleared == '0);
   end

   assign out_index = scan_index;
   assign out_last  = scan_last;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= StIdle;
         residual  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (in_valid && in_ready) begin
                  residual <= in_data;
                  in_ready <= 1'b0;
                  if (in_data != '0) begin
                     state     <= StScan;
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     // Empty mask: straight to the completion pulse, nothing emitted.
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            StScan: begin
               if (out_ready) begin
                  residual <= residual_next;
                  if (scan_last) begin
                     state     <= StDone;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            StDone: begin
               done     <= 1'b0;
               in_ready <= 1'b1;
               state    <= StIdle;
            end
            default: begin
               state     <= StIdle;
               residual  <= '0;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_scan_unpacker.sv
// Directed bench for bit_scan_unpacker; expected orders follow BITSCAN_MSB_FIRST_EN.
module tb_bit_scan_unpacker;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   bit_scan_unpacker #(.WIDTH(32), .IDXW(5)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [4:0] idx,
                            input logic last);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".index"}, 32'(out_index), 32'(idx));
      check({tag, ".last"},  32'(out_last),  32'(last));
   endtask

   logic [4:0] exp_a [3];
   logic [4:0] exp_b [2];
   logic [4:0] exp_f;
   logic [4:0] exp_idx;

   initial begin
`ifdef BITSCAN_MSB_FIRST_EN
      exp_a = '{5'd31, 5'd4, 5'd0};
      exp_b = '{5'd2, 5'd1};
      exp_f = 5'd6;
`else
      exp_a = '{5'd0, 5'd4, 5'd31};
      exp_b = '{5'd1, 5'd2};
      exp_f = 5'd5;
`endif
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1234;
      out_ready = 1'b1;

      // Reset held three cycles with a mask offered
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst.in_ready", 32'(in_ready), 0);
         check("rst.busy", 32'(busy), 0);
         check("rst.done", 32'(done), 0);
         check_out("rst", 1'b0, 5'd0, 1'b0);
      end
      reset_n = 1'b1;
      tick();
      check("rel.in_ready", 32'(in_ready), 1);
      check("rel.busy", 32'(busy), 0);
      check("rel.valid", 32'(out_valid), 0);
      in_valid = 1'b0;
      tick();

      // Three-bit mask, full throughput
      in_valid = 1'b1;
      in_data  = 32'h8000_0011;
      tick();
      in_valid = 1'b0;
      check("a.busy", 32'(busy), 1);
      check("a.in_ready", 32'(in_ready), 0);
      for (int k = 0; k < 3; k++) begin
         check_out("a", 1'b1, exp_a[k], k == 2);
         tick();
      end
      check("a.done", 32'(done), 1);
      check("a.done_busy", 32'(busy), 0);
      check("a.done_valid", 32'(out_valid), 0);
      check("a.done_rdy", 32'(in_ready), 0);
      tick();
      check("a.done_end", 32'(done), 0);
      check("a.rdy_back", 32'(in_ready), 1);

      // Empty mask
      in_valid = 1'b1;
      in_data  = 32'h0;
      tick();
      in_valid = 1'b0;
      check("z.done", 32'(done), 1);
      check("z.valid", 32'(out_valid), 0);
      tick();
      check("z.done_end", 32'(done), 0);
      check("z.valid2", 32'(out_valid), 0);
      check("z.rdy_back", 32'(in_ready), 1);

      // Backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0006;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_out("bp.hold", 1'b1, exp_b[0], 1'b0);
         if (c < 2) tick();
      end
      out_ready = 1'b1;
      tick();
      check_out("bp.second", 1'b1, exp_b[1], 1'b1);
      tick();
      check("bp.done", 32'(done), 1);
      check("bp.valid", 32'(out_valid), 0);
      tick();
      check("bp.rdy_back", 32'(in_ready), 1);

      // All ones, with a stray mask offered mid-scan
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 32; k++) begin
         exp_idx = 5'(k);
`ifdef BITSCAN_MSB_FIRST_EN
         exp_idx = 5'(31 - k);
`endif
         check_out("ones", 1'b1, exp_idx, k == 31);
         check("ones.busy", 32'(busy), 1);
         in_valid = (k == 5);
         in_data  = (k == 5) ? 32'h1 : 32'hFFFF_FFFF;
         tick();
      end
      in_valid = 1'b0;
      check("ones.done", 32'(done), 1);
      check("ones.valid", 32'(out_valid), 0);
      tick();
      check("ones.rdy_back", 32'(in_ready), 1);
      check("ones.no_stray", 32'(out_valid), 0);

      // Reset mid-scan
      in_valid = 1'b1;
      in_data  = 32'h0000_00F0;
      tick();
      in_valid = 1'b0;
      check_out("mid.first", 1'b1, exp_a[0] == 5'd0 ? 5'd4 : 5'd7, 1'b0);
      tick();
      check_out("mid.second", 1'b1, exp_f, 1'b0);
      reset_n = 1'b0;
      #1;
      check_out("mid.async", 1'b0, 5'd0, 1'b0);
      check("mid.busy", 32'(busy), 0);
      check("mid.in_ready", 32'(in_ready), 0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         check("post.valid", 32'(out_valid), 0);
         check("post.done", 32'(done), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
